pipe_decode_ctrl: RTL
=====================

Name: pipe_decode_ctrl

Overview:
Pipelined successor to the single-cycle control unit. It decodes the RV32I instruction in the Decode (D) stage and registers the control bundle into the ID/EX pipeline register. It detects load-use hazards and stalls Fetch/Decode. It applies EX-stage branch/jump flushes by inserting bubbles. It sits between the IF/ID register and the Execute datapath.

Parameters:
DATA_WIDTH, 32, instruction width
REG_ADDR_WIDTH, 5, register index width
ALU_CTRL_WIDTH, 4, ALU opcode width (widened from 3)
HAZARD_EN, 1, 1 = load-use stall logic active; 0 = stall_fd_o tied 0
CNT_WIDTH, 16, bubble counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
instr_d  in  DATA_WIDTH  instruction from IF/ID
valid_d  in  1  instr_d holds a real instruction
flush_e_i  in  1  taken branch/jump resolved in EX this cycle
imm_src_d  out  3  combinational immediate format for D-stage extender: 000 I, 001 S, 010 B, 011 U, 100 J
stall_fd_o  out  1  combinational: hold PC and IF/ID
valid_e  out  1  E-stage entry is real
reg_write_e  out  1  register write enable
alu_src_e  out  1  1 = immediate operand B
alu_a_pc_e  out  1  1 = PC as operand A (AUIPC)
alu_ctrl_e  out  ALU_CTRL_WIDTH  ALU operation
result_src_e  out  2  00 ALU, 01 mem, 10 PC+4, 11 immediate
mem_read_e  out  1  load
mem_write_e  out  1  store
addr_mode_e  out  3  data-memory mode
branch_e  out  1  conditional branch
br_funct3_e  out  3  branch condition for EX comparator
jump_e  out  1  JAL
jalr_e  out  1  JALR
illegal_e  out  1  unsupported opcode/funct
rd_e, rs1_e, rs2_e  out  REG_ADDR_WIDTH each  register indices
bubble_cnt_o  out  CNT_WIDTH  count of inserted bubbles

Behaviour:
- Reset: all *_e outputs and bubble_cnt_o are 0. The stage then holds a bubble.
- Latency: decode is combinational in D. Outputs appear on the *_e registers one clk edge later.
- ALU codes:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT.
  - 0110 SLTU, 0111 SLL, 1000 SRL, 1001 SRA, 1010 PASS_B.
  - The 3-bit legacy codes keep their values.
- R-type:
  - funct7 0100000 selects SUB (funct3 000) or SRA (funct3 101).
  - Any funct7 other than 0000000 or 0100000 is illegal.
- I-arith:
  - SLLI/SRLI/SRAI use instr[30] to pick SRL vs SRA.
  - A shift with an imm[11:5] value other than 0000000 or 0100000 is illegal.
- addr_mode (unchanged encoding): LB 000, LH 001, LW 010, LBU 011, LHU 100, SB 101, SH 110, SW 111. Other funct3 values are illegal.
- Branch: funct3 ∈ {000,001,100,101,110,111} is legal and passed through as br_funct3_e. alu_ctrl_e = SUB. 010 and 011 are illegal.
- JAL: jump_e=1, reg_write_e=1, result_src_e=10.
- JALR: jalr_e=1, reg_write_e=1, result_src_e=10, alu_src_e=1.
- LUI: alu_ctrl_e = PASS_B, alu_src_e=1.
- AUIPC: alu_a_pc_e=1, alu_ctrl_e = ADD, alu_src_e=1.
- SYSTEM funct3=000 (ecall/ebreak) is a NOP. Any other SYSTEM instruction is illegal.
- reg_write_e is forced 0 whenever rd = 0, for every opcode.
- Illegal instructions: valid_e=1, illegal_e=1, every other enable 0.
- Operand use:
  - rs1 is used by all opcodes except LUI, AUIPC, JAL.
  - rs2 is used by R, S, B.
- Load-use stall, combinational: stall_fd_o = HAZARD_EN & valid_d & valid_e & mem_read_e & (rd_e≠0) & ((use_rs1 & rs1_d==rd_e) | (use_rs2 & rs2_d==rd_e)) & ~flush_e_i.
- Each edge, the E register loads:
  - rst → reset state.
  - else flush_e_i → bubble (flush wins over stall).
  - else stall_fd_o → bubble.
  - else valid_d=0 → bubble.
  - else decoded bundle.
- A bubble is all enables 0, valid_e 0, and register indices 0.
- bubble_cnt_o increments on each flush- or stall-induced bubble. It saturates at all-ones and does not wrap. A valid_d=0 bubble is not counted.
- A stall lasts exactly one cycle per load-use pair. The next cycle's E entry is a bubble, so the condition clears.
- Reset asserted mid-stall: stall_fd_o drops the cycle after the reset edge because valid_e=0.

Decomposition:
- Package ctrl_pkg holds:
  - alu_op_e enum (4-bit), imm_src_e, result_src_e, addr_mode_e.
  - Opcode constants.
  - ctrl_bundle_t struct, with a CTRL_BUBBLE constant.
- Sub-module ctrl_decode: purely combinational, instr → ctrl_bundle_t, use_rs1, use_rs2, imm_src.
- The top level holds the hazard logic, the ID/EX register and the counter.

Test Plan:
- Reset: hold rst 2 cycles with instr_d = 0x00500093 (addi x1,x0,5) → all *_e 0, bubble_cnt_o 0.
- After reset, instr_d = addi x1,x0,5 → next cycle valid_e=1, reg_write_e=1, alu_src_e=1, alu_ctrl_e=0000, rd_e=1.
- Load-use: lw x5,0(x2) (0x00012283), then add x6,x5,x1 (0x00128333) → stall_fd_o=1 for one cycle, bubble in E, add issued next cycle, bubble_cnt_o=1.
- No false stall: lw x0,0(x2), then add x6,x0,x1 → stall_fd_o=0.
- Flush during stall: the stall condition from the load-use test plus flush_e_i=1 → stall_fd_o=0, bubble loaded, bubble_cnt_o increments by exactly 1.
- Decode edges:
  - sra x3,x1,x2 (0x4020D1B3) → alu_ctrl_e=1001.
  - bgeu (funct3 111) → branch_e=1, br_funct3_e=111.
  - opcode 0x7F → illegal_e=1, reg_write_e=0.
- Saturation: with CNT_WIDTH=4, 20 consecutive flushes → bubble_cnt_o holds 0xF.

Source files
------------

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared control types, opcodes and the ALU-op helper for pipe_decode_ctrl
package ctrl_pkg;
    typedef enum logic [3:0] {
        ALU_ADD    = 4'b0000,
        ALU_SUB    = 4'b0001,
        ALU_AND    = 4'b0010,
        ALU_OR     = 4'b0011,
        ALU_XOR    = 4'b0100,
        ALU_SLT    = 4'b0101,
        ALU_SLTU   = 4'b0110,
        ALU_SLL    = 4'b0111,
        ALU_SRL    = 4'b1000,
        ALU_SRA    = 4'b1001,
        ALU_PASS_B = 4'b1010
    } alu_op_e;
    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_U = 3'b011,
        IMM_J = 3'b100
    } imm_src_e;
    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10,
        RES_IMM = 2'b11
    } result_src_e;
    typedef enum logic [2:0] {
        AM_LB  = 3'b000,
        AM_LH  = 3'b001,
        AM_LW  = 3'b010,
        AM_LBU = 3'b011,
        AM_LHU = 3'b100,
        AM_SB  = 3'b101,
        AM_SH  = 3'b110,
        AM_SW  = 3'b111
    } addr_mode_e;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    typedef struct packed {
        logic        valid;
        logic        reg_write;
        logic        alu_src;
        logic        alu_a_pc;
        alu_op_e     alu_ctrl;
        result_src_e result_src;
        logic        mem_read;
        logic        mem_write;
        addr_mode_e  addr_mode;
        logic        branch;
        logic [2:0]  br_funct3;
        logic        jump;
        logic        jalr;
        logic        illegal;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
    } ctrl_bundle_t;
    localparam ctrl_bundle_t CTRL_BUBBLE = '0;
    // alt is instr[30]; it only matters for ADD/SUB and SRL/SRA
    function automatic alu_op_e alu_fn(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction
endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational RV32I decode of one instruction into a control bundle
//   instr_i      instruction word
//   ctrl_o       decoded control bundle (illegal => only valid/illegal set)
//   use_rs1_o    instruction reads rs1
//   use_rs2_o    instruction reads rs2
//   imm_src_o    immediate format for the D-stage extender
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [31:0]  instr_i,
    output ctrl_bundle_t ctrl_o,
    output logic         use_rs1_o,
    output logic         use_rs2_o,
    output imm_src_e     imm_src_o
);
    logic [6:0] op;
    logic [6:0] f7;
    logic [2:0] f3;
    logic [4:0] rd;
    logic       ill;
    ctrl_bundle_t b;
    assign op = instr_i[6:0];
    assign rd = instr_i[11:7];
    assign f3 = instr_i[14:12];
    assign f7 = instr_i[31:25];
    always_comb begin
        b           = CTRL_BUBBLE;
        b.valid     = 1'b1;
        b.rd        = rd;
        b.rs1       = instr_i[19:15];
        b.rs2       = instr_i[24:20];
        ill         = 1'b0;
        imm_src_o   = IMM_I;
        case (op)
            OP_R: begin
                ill         = f7 != 7'h00 && f7 != 7'h20;
                b.reg_write = 1'b1;
                b.alu_ctrl  = alu_fn(f3, instr_i[30]);
            end
            OP_I: begin
                ill         = (f3 == 3'b001 || f3 == 3'b101) && f7 != 7'h00 && f7 != 7'h20;
                b.reg_write = 1'b1;
                b.alu_src   = 1'b1;
                b.alu_ctrl  = alu_fn(f3, f3 == 3'b101 && instr_i[30]);
            end
            OP_LOAD: begin
                b.mem_read   = 1'b1;
                b.reg_write  = 1'b1;
                b.alu_src    = 1'b1;
                b.result_src = RES_MEM;
                case (f3)
                    3'b000:  b.addr_mode = AM_LB;
                    3'b001:  b.addr_mode = AM_LH;
                    3'b010:  b.addr_mode = AM_LW;
                    3'b100:  b.addr_mode = AM_LBU;
                    3'b101:  b.addr_mode = AM_LHU;
                    default: ill = 1'b1;
                endcase
            end
            OP_STORE: begin
                imm_src_o   = IMM_S;
                b.mem_write = 1'b1;
                b.alu_src   = 1'b1;
                case (f3)
                    3'b000:  b.addr_mode = AM_SB;
                    3'b001:  b.addr_mode = AM_SH;
                    3'b010:  b.addr_mode = AM_SW;
                    default: ill = 1'b1;
                endcase
            end
            OP_BRANCH: begin
                imm_src_o   = IMM_B;
                ill         = f3[2:1] == 2'b01;
                b.branch    = 1'b1;
                b.br_funct3 = f3;
                b.alu_ctrl  = ALU_SUB;
            end
            OP_JAL: begin
                imm_src_o    = IMM_J;
                b.jump       = 1'b1;
                b.reg_write  = 1'b1;
                b.result_src = RES_PC4;
            end
            OP_JALR: begin
                b.jalr       = 1'b1;
                b.reg_write  = 1'b1;
                b.alu_src    = 1'b1;
                b.result_src = RES_PC4;
            end
            OP_LUI: begin
                imm_src_o   = IMM_U;
                b.reg_write = 1'b1;
                b.alu_src   = 1'b1;
                b.alu_ctrl  = ALU_PASS_B;
            end
            OP_AUIPC: begin
                imm_src_o   = IMM_U;
                b.reg_write = 1'b1;
                b.alu_src   = 1'b1;
                b.alu_a_pc  = 1'b1;
            end
            OP_SYSTEM: ill = f3 != 3'b000;
            default:   ill = 1'b1;
        endcase
        b.reg_write = b.reg_write && rd != 5'd0;
        if (ill) begin
            b         = CTRL_BUBBLE;
            b.valid   = 1'b1;
            b.illegal = 1'b1;
            b.rd      = rd;
            b.rs1     = instr_i[19:15];
            b.rs2     = instr_i[24:20];
        end
        ctrl_o = b;
    end
    assign use_rs1_o = !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
    assign use_rs2_o = op == OP_R || op == OP_STORE || op == OP_BRANCH;
endmodule

// File: rtl/pipe_decode_ctrl.sv
// pipe_decode_ctrl: D-stage decode, load-use stall, flush bubbles and the ID/EX control register
//   instr_d/valid_d   instruction from IF/ID
//   flush_e_i         taken branch/jump resolved in EX
//   imm_src_d         D-stage immediate format (combinational)
//   stall_fd_o        hold PC and IF/ID (combinational)
//   *_e               registered E-stage control bundle
//   bubble_cnt_o      saturating count of flush/stall bubbles
module pipe_decode_ctrl
    import ctrl_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int ALU_CTRL_WIDTH = 4,
    parameter int HAZARD_EN      = 1,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_WIDTH-1:0]     instr_d,
    input  logic                      valid_d,
    input  logic                      flush_e_i,
    output logic [2:0]                imm_src_d,
    output logic                      stall_fd_o,
    output logic                      valid_e,
    output logic                      reg_write_e,
    output logic                      alu_src_e,
    output logic                      alu_a_pc_e,
    output logic [ALU_CTRL_WIDTH-1:0] alu_ctrl_e,
    output logic [1:0]                result_src_e,
    output logic                      mem_read_e,
    output logic                      mem_write_e,
    output logic [2:0]                addr_mode_e,
    output logic                      branch_e,
    output logic [2:0]                br_funct3_e,
    output logic                      jump_e,
    output logic                      jalr_e,
    output logic                      illegal_e,
    output logic [REG_ADDR_WIDTH-1:0] rd_e,
    output logic [REG_ADDR_WIDTH-1:0] rs1_e,
    output logic [REG_ADDR_WIDTH-1:0] rs2_e,
    output logic [CNT_WIDTH-1:0]      bubble_cnt_o
);
    ctrl_bundle_t         dec;
    ctrl_bundle_t         e_d, e_q;
    logic                 use_rs1, use_rs2;
    imm_src_e             imm_src;
    logic [CNT_WIDTH-1:0] cnt_d, cnt_q;
    ctrl_decode u_dec (
        .instr_i   (instr_d[31:0]),
        .ctrl_o    (dec),
        .use_rs1_o (use_rs1),
        .use_rs2_o (use_rs2),
        .imm_src_o (imm_src)
    );
    assign imm_src_d = imm_src;
    // A flush already kills the dependent instruction, so it never needs to stall
    assign stall_fd_o = HAZARD_EN != 0 && valid_d && e_q.valid && e_q.mem_read && e_q.rd != 5'd0 &&
                        ((use_rs1 && dec.rs1 == e_q.rd) || (use_rs2 && dec.rs2 == e_q.rd)) && !flush_e_i;
    always_comb begin
        e_d   = (flush_e_i || stall_fd_o || !valid_d) ? CTRL_BUBBLE : dec;
        cnt_d = ((flush_e_i || stall_fd_o) && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            e_q   <= CTRL_BUBBLE;
            cnt_q <= '0;
        end else begin
            e_q   <= e_d;
            cnt_q <= cnt_d;
        end
    end
    assign valid_e      = e_q.valid;
    assign reg_write_e  = e_q.reg_write;
    assign alu_src_e    = e_q.alu_src;
    assign alu_a_pc_e   = e_q.alu_a_pc;
    assign alu_ctrl_e   = ALU_CTRL_WIDTH'(e_q.alu_ctrl);
    assign result_src_e = e_q.result_src;
    assign mem_read_e   = e_q.mem_read;
    assign mem_write_e  = e_q.mem_write;
    assign addr_mode_e  = e_q.addr_mode;
    assign branch_e     = e_q.branch;
    assign br_funct3_e  = e_q.br_funct3;
    assign jump_e       = e_q.jump;
    assign jalr_e       = e_q.jalr;
    assign illegal_e    = e_q.illegal;
    assign rd_e         = REG_ADDR_WIDTH'(e_q.rd);
    assign rs1_e        = REG_ADDR_WIDTH'(e_q.rs1);
    assign rs2_e        = REG_ADDR_WIDTH'(e_q.rs2);
    assign bubble_cnt_o = cnt_q;
endmodule
